// File: rtl/vga_tta_core.sv
// vga_tta_core: small transport-triggered controller for VGA timing/pixel
// sequencing. One instruction per cycle from an external instruction memory,
// a 16-entry register file, a single ALU result register, an MDR for the
// last memory read, and a blocking single-outstanding memory port.
module vga_tta_core (
    input  logic        clock_i,
    input  logic        reset_ni,
    output logic [15:0] pc_o,
    input  logic        hit_i,
    input  logic [31:0] instr_i,
    output logic        newline_o,
    output logic        newpage_o,
    output logic        m_read_o,
    output logic        m_write_o,
    input  logic        m_ready_i,
    output logic [3:0]  m_addr_o,
    input  logic [15:0] m_data_i,
    output logic [15:0] m_data_o
);

    typedef enum logic [1:0] {
        MS_IDLE  = 2'd0,
        MS_READ  = 2'd1,
        MS_WRITE = 2'd2
    } mem_state_e;

    mem_state_e  r_state;
    mem_state_e  w_state_next;

    logic [15:0] r_pc;
    logic [15:0] r_alu;
    logic [15:0] r_mdr;
    logic        r_newline;
    logic        r_newpage;
    logic [3:0]  r_maddr;
    logic [15:0] r_mdata;
    logic [15:0] r_rf [16];

    logic [8:0]  w_imm_f;
    logic [3:0]  w_rs;
    logic [3:0]  w_rd;
    logic [1:0]  w_wsrc;
    logic [2:0]  w_com_sel;
    logic        w_mem;
    logic [1:0]  w_ctl;
    logic [1:0]  w_bsel;
    logic [2:0]  w_aop;
    logic [1:0]  w_asel;

    logic [15:0] w_imm;
    logic [15:0] w_rs_val;
    logic [15:0] w_com;
    logic [15:0] w_alu_a;
    logic [15:0] w_alu_b;
    logic [15:0] w_alu_res;
    logic [15:0] w_rf_wdata;
    logic        w_exec;

    // Instruction field decode
    always_comb begin
        w_imm_f   = instr_i[31:23];
        w_rs      = instr_i[22:19];
        w_rd      = instr_i[18:15];
        w_wsrc    = instr_i[14:13];
        w_com_sel = instr_i[12:10];
        w_mem     = instr_i[9];
        w_ctl     = instr_i[8:7];
        w_bsel    = instr_i[6:5];
        w_aop     = instr_i[4:2];
        w_asel    = instr_i[1:0];
        w_imm     = {7'd0, w_imm_f};
        w_rs_val  = r_rf[w_rs];
    end

    // An instruction only takes effect when it is valid and no access is outstanding
    always_comb begin
        w_exec = hit_i && (r_state == MS_IDLE);
    end

    // COM bus source select
    always_comb begin
        w_com = '0;
        case (w_com_sel)
            3'b000:  w_com = w_rs_val;
            3'b001:  w_com = w_imm;
            3'b010:  w_com = r_alu;
            3'b011:  w_com = r_mdr;
            3'b100:  w_com = r_pc;
            default: w_com = '0;
        endcase
    end

    // ALU operand selection and operation
    always_comb begin
        w_alu_a = '0;
        case (w_asel)
            2'b01:   w_alu_a = w_rs_val;
            2'b10:   w_alu_a = w_com;
            2'b11:   w_alu_a = w_imm;
            default: w_alu_a = '0;
        endcase

        w_alu_b = '0;
        case (w_bsel)
            2'b00:   w_alu_b = w_com;
            2'b01:   w_alu_b = w_imm;
            2'b10:   w_alu_b = w_rs_val;
            default: w_alu_b = 16'd1;
        endcase

        w_alu_res = '0;
        case (w_aop)
            3'b000:  w_alu_res = w_alu_a & w_alu_b;
            3'b001:  w_alu_res = w_alu_a | w_alu_b;
            3'b010:  w_alu_res = w_alu_a ^ w_alu_b;
            3'b011:  w_alu_res = w_alu_a + w_alu_b;
            3'b100:  w_alu_res = w_alu_a - w_alu_b;
            3'b101:  w_alu_res = w_alu_a >> 1;
            3'b110:  w_alu_res = w_alu_a + 16'd1;
            default: w_alu_res = w_alu_a;
        endcase
    end

    // Register-file write data select (ALU source is the value before this cycle's update)
    always_comb begin
        w_rf_wdata = '0;
        case (w_wsrc)
            2'b01:   w_rf_wdata = r_alu;
            2'b10:   w_rf_wdata = w_com;
            2'b11:   w_rf_wdata = w_imm;
            default: w_rf_wdata = '0;
        endcase
    end

    // Memory handshake next-state: launch on an executing mem instruction, retire on ready
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            MS_IDLE: begin
                if (w_exec && w_mem) begin
                    w_state_next = w_imm_f[8] ? MS_WRITE : MS_READ;
                end
            end
            MS_READ, MS_WRITE: begin
                if (m_ready_i) begin
                    w_state_next = MS_IDLE;
                end
            end
            default: w_state_next = MS_IDLE;
        endcase
    end

    // Memory handshake state register; reset drops any outstanding request at once
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state <= MS_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Program counter, ALU result, MDR, display pulses and memory address/data
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_pc      <= 16'h0001;
            r_alu     <= '0;
            r_mdr     <= '0;
            r_newline <= 1'b0;
            r_newpage <= 1'b0;
            r_maddr   <= '0;
            r_mdata   <= '0;
        end else begin
            r_newline <= w_exec && (w_ctl == 2'b01);
            r_newpage <= w_exec && (w_ctl == 2'b10);
            if (w_exec) begin
                if (w_ctl == 2'b11) begin
                    r_pc <= w_imm;
                end else begin
                    r_pc <= r_pc + 16'd1;
                end
                if (w_asel != 2'b00) begin
                    r_alu <= w_alu_res;
                end
                if (w_mem) begin
                    r_maddr <= w_imm_f[3:0];
                    r_mdata <= w_com;
                end
            end
            if ((r_state == MS_READ) && m_ready_i) begin
                r_mdr <= m_data_i;
            end
        end
    end

    // Register file write port; contents survive reset, but no writes land while it is held
    always_ff @(posedge clock_i) begin
        if (reset_ni && w_exec && (w_wsrc != 2'b00)) begin
            r_rf[w_rd] <= w_rf_wdata;
        end
    end

    // Output drive
    always_comb begin
        pc_o      = r_pc;
        newline_o = r_newline;
        newpage_o = r_newpage;
        m_read_o  = (r_state == MS_READ);
        m_write_o = (r_state == MS_WRITE);
        m_addr_o  = r_maddr;
        m_data_o  = r_mdata;
    end

endmodule

// File: tb/tb_vga_tta_core.sv
// tb_vga_tta_core: directed vector table for vga_tta_core plus hand-written
// reset sequences. Each vector drives one cycle of inputs and lists the
// outputs expected just after the following rising edge.
module tb_vga_tta_core;

    logic        clock_i;
    logic        reset_ni;
    logic [15:0] pc_o;
    logic        hit_i;
    logic [31:0] instr_i;
    logic        newline_o;
    logic        newpage_o;
    logic        m_read_o;
    logic        m_write_o;
    logic        m_ready_i;
    logic [3:0]  m_addr_o;
    logic [15:0] m_data_i;
    logic [15:0] m_data_o;

    int unsigned n_checks;
    int unsigned n_errors;

    vga_tta_core u_dut (
        .clock_i   (clock_i),
        .reset_ni  (reset_ni),
        .pc_o      (pc_o),
        .hit_i     (hit_i),
        .instr_i   (instr_i),
        .newline_o (newline_o),
        .newpage_o (newpage_o),
        .m_read_o  (m_read_o),
        .m_write_o (m_write_o),
        .m_ready_i (m_ready_i),
        .m_addr_o  (m_addr_o),
        .m_data_i  (m_data_i),
        .m_data_o  (m_data_o)
    );

    initial clock_i = 1'b0;
    always #5 clock_i = ~clock_i;

    typedef struct {
        logic        hit;
        logic [31:0] instr;
        logic        rdy;
        logic [15:0] mdi;
        logic [15:0] pc;
        logic        nl;
        logic        np;
        logic        rd;
        logic        wr;
        logic [3:0]  addr;
        logic [15:0] data;
    } vec_t;

    vec_t vecs[$];

    localparam logic [31:0] NOP = 32'h0000_001C;

    function automatic logic [31:0] mk(input logic [8:0] imm, input logic [3:0] rs,
                                       input logic [3:0] rd, input logic [1:0] wsrc,
                                       input logic [2:0] com, input logic mem,
                                       input logic [1:0] ctl, input logic [1:0] bsel,
                                       input logic [2:0] aop, input logic [1:0] asel);
        return {imm, rs, rd, wsrc, com, mem, ctl, bsel, aop, asel};
    endfunction

    task automatic add(input logic hit, input logic [31:0] instr, input logic rdy,
                       input logic [15:0] mdi, input logic [15:0] pc, input logic nl,
                       input logic np, input logic rd, input logic wr,
                       input logic [3:0] addr, input logic [15:0] data);
        vec_t v;
        v.hit = hit; v.instr = instr; v.rdy = rdy; v.mdi = mdi;
        v.pc = pc; v.nl = nl; v.np = np; v.rd = rd; v.wr = wr;
        v.addr = addr; v.data = data;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input logic [15:0] act,
                         input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic check_all(input int idx, input logic [15:0] pc, input logic nl,
                             input logic np, input logic rd, input logic wr,
                             input logic [3:0] addr, input logic [15:0] data);
        check("pc_o", idx, pc_o, pc);
        check("newline_o", idx, {15'd0, newline_o}, {15'd0, nl});
        check("newpage_o", idx, {15'd0, newpage_o}, {15'd0, np});
        check("m_read_o", idx, {15'd0, m_read_o}, {15'd0, rd});
        check("m_write_o", idx, {15'd0, m_write_o}, {15'd0, wr});
        check("m_addr_o", idx, {12'd0, m_addr_o}, {12'd0, addr});
        check("m_data_o", idx, m_data_o, data);
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        reset_ni  = 1'b0;
        hit_i     = 1'b0;
        instr_i   = NOP;
        m_ready_i = 1'b0;
        m_data_i  = '0;

        //   hit instr                                                   rdy mdi       pc  nl np rd wr addr data
        add(1, NOP,                                                   0, 16'h0,  16'd2, 0, 0, 0, 0, 4'd0, 16'h0000);
        add(1, NOP,                                                   0, 16'h0,  16'd3, 0, 0, 0, 0, 4'd0, 16'h0000);
        add(0, NOP,                                                   0, 16'h0,  16'd3, 0, 0, 0, 0, 4'd0, 16'h0000);
        add(0, mk(9'd1, 0, 0, 0, 0, 0, 2'b11, 0, 3'd7, 0),            0, 16'h0,  16'd3, 0, 0, 0, 0, 4'd0, 16'h0000);
        add(1, NOP,                                                   0, 16'h0,  16'd4, 0, 0, 0, 0, 4'd0, 16'h0000);
        // r0 = 11; alu = r0 + 1; r1 = alu; write r1 to port 3
        add(1, mk(9'd11, 0, 0, 2'b11, 0, 0, 0, 0, 0, 0),              0, 16'h0,  16'd5, 0, 0, 0, 0, 4'd0, 16'h0000);
        add(1, mk(9'd0, 0, 0, 0, 0, 0, 0, 2'b11, 3'd3, 2'b01),        0, 16'h0,  16'd6, 0, 0, 0, 0, 4'd0, 16'h0000);
        add(1, mk(9'd0, 1, 1, 2'b01, 3'd0, 0, 0, 0, 0, 0),            0, 16'h0,  16'd7, 0, 0, 0, 0, 4'd0, 16'h0000);
        add(1, mk(9'h103, 1, 0, 0, 3'd0, 1, 0, 0, 0, 0),              0, 16'h0,  16'd8, 0, 0, 0, 1, 4'd3, 16'd12);
        add(1, mk(9'h055, 0, 0, 0, 0, 0, 2'b11, 0, 3'd7, 0),          1, 16'h0,  16'd8, 0, 0, 0, 0, 4'd3, 16'd12);
        add(1, NOP,                                                   0, 16'h0,  16'd9, 0, 0, 0, 0, 4'd3, 16'd12);
        // jump to 1, newline and newpage pulses, stray ready ignored
        add(1, mk(9'd1, 0, 0, 0, 0, 0, 2'b11, 0, 3'd7, 0),            0, 16'h0,  16'd1, 0, 0, 0, 0, 4'd3, 16'd12);
        add(1, mk(9'd0, 0, 0, 0, 0, 0, 2'b01, 0, 3'd7, 0),            0, 16'h0,  16'd2, 1, 0, 0, 0, 4'd3, 16'd12);
        add(1, NOP,                                                   0, 16'h0,  16'd3, 0, 0, 0, 0, 4'd3, 16'd12);
        add(1, mk(9'd0, 0, 0, 0, 0, 0, 2'b10, 0, 3'd7, 0),            0, 16'h0,  16'd4, 0, 1, 0, 0, 4'd3, 16'd12);
        add(1, NOP,                                                   1, 16'h0,  16'd5, 0, 0, 0, 0, 4'd3, 16'd12);
        // r2 = 5; then read r2 while writing it: alu gets old 5, r2 becomes 7
        add(1, mk(9'd5, 0, 2, 2'b11, 0, 0, 0, 0, 0, 0),               0, 16'h0,  16'd6, 0, 0, 0, 0, 4'd3, 16'd12);
        add(1, mk(9'd7, 2, 2, 2'b11, 0, 0, 0, 0, 3'd7, 2'b01),        0, 16'h0,  16'd7, 0, 0, 0, 0, 4'd3, 16'd12);
        add(1, mk(9'h102, 0, 0, 0, 3'd2, 1, 0, 0, 0, 0),              0, 16'h0,  16'd8, 0, 0, 0, 1, 4'd2, 16'd5);
        add(1, NOP,                                                   1, 16'h0,  16'd8, 0, 0, 0, 0, 4'd2, 16'd5);
        add(1, mk(9'h104, 2, 0, 0, 3'd0, 1, 0, 0, 0, 0),              0, 16'h0,  16'd9, 0, 0, 0, 1, 4'd4, 16'd7);
        add(1, NOP,                                                   0, 16'h0,  16'd9, 0, 0, 0, 1, 4'd4, 16'd7);
        add(1, NOP,                                                   1, 16'h0,  16'd9, 0, 0, 0, 0, 4'd4, 16'd7);
        // 0 - 1 wraps to FFFF
        add(1, mk(9'd0, 0, 0, 0, 0, 0, 0, 2'b11, 3'd4, 2'b11),        0, 16'h0,  16'd10, 0, 0, 0, 0, 4'd4, 16'd7);
        add(1, mk(9'h101, 0, 0, 0, 3'd2, 1, 0, 0, 0, 0),              0, 16'h0,  16'd11, 0, 0, 0, 1, 4'd1, 16'hFFFF);
        add(1, NOP,                                                   1, 16'h0,  16'd11, 0, 0, 0, 0, 4'd1, 16'hFFFF);
        // read from port 5, ready on third request cycle, then write MDR out
        add(1, mk(9'h005, 0, 0, 0, 3'd5, 1, 0, 0, 0, 0),              0, 16'h0,  16'd12, 0, 0, 1, 0, 4'd5, 16'h0000);
        add(1, NOP,                                                   0, 16'h0,  16'd12, 0, 0, 1, 0, 4'd5, 16'h0000);
        add(1, NOP,                                                   0, 16'h0,  16'd12, 0, 0, 1, 0, 4'd5, 16'h0000);
        add(1, NOP,                                                   1, 16'hBEEF, 16'd12, 0, 0, 0, 0, 4'd5, 16'h0000);
        add(1, mk(9'h106, 0, 0, 0, 3'd3, 1, 0, 0, 0, 0),              0, 16'h0,  16'd13, 0, 0, 0, 1, 4'd6, 16'hBEEF);
        add(1, NOP,                                                   1, 16'h0,  16'd13, 0, 0, 0, 0, 4'd6, 16'hBEEF);
        // 0x155 >> 1 = 0xAA; 0xAA ^ 0xFF = 0x55
        add(1, mk(9'h155, 0, 0, 0, 0, 0, 0, 2'b11, 3'd5, 2'b11),      0, 16'h0,  16'd14, 0, 0, 0, 0, 4'd6, 16'hBEEF);
        add(1, mk(9'h0FF, 0, 0, 0, 3'd2, 0, 0, 2'b01, 3'd2, 2'b10),   0, 16'h0,  16'd15, 0, 0, 0, 0, 4'd6, 16'hBEEF);
        add(1, mk(9'h107, 0, 0, 0, 3'd2, 1, 0, 0, 0, 0),              0, 16'h0,  16'd16, 0, 0, 0, 1, 4'd7, 16'h0055);
        add(1, NOP,                                                   1, 16'h0,  16'd16, 0, 0, 0, 0, 4'd7, 16'h0055);
        // COM = pc (16) written out
        add(1, mk(9'h108, 0, 0, 0, 3'd4, 1, 0, 0, 0, 0),              0, 16'h0,  16'd17, 0, 0, 0, 1, 4'd8, 16'd16);
        add(1, NOP,                                                   1, 16'h0,  16'd17, 0, 0, 0, 0, 4'd8, 16'd16);
        // r1 (12) + 1 = 13
        add(1, mk(9'd0, 1, 0, 0, 0, 0, 0, 0, 3'd6, 2'b01),            0, 16'h0,  16'd18, 0, 0, 0, 0, 4'd8, 16'd16);
        add(1, mk(9'h109, 0, 0, 0, 3'd2, 1, 0, 0, 0, 0),              0, 16'h0,  16'd19, 0, 0, 0, 1, 4'd9, 16'd13);
        add(1, NOP,                                                   1, 16'h0,  16'd19, 0, 0, 0, 0, 4'd9, 16'd13);

        // Reset state
        repeat (2) @(posedge clock_i);
        #1;
        check_all(-1, 16'd1, 0, 0, 0, 0, 4'd0, 16'h0000);
        reset_ni = 1'b1;
        hit_i    = 1'b1;
        #1;
        check_all(-2, 16'd1, 0, 0, 0, 0, 4'd0, 16'h0000);

        foreach (vecs[i]) begin
            hit_i     = vecs[i].hit;
            instr_i   = vecs[i].instr;
            m_ready_i = vecs[i].rdy;
            m_data_i  = vecs[i].mdi;
            @(posedge clock_i);
            #1;
            check_all(i, vecs[i].pc, vecs[i].nl, vecs[i].np, vecs[i].rd, vecs[i].wr,
                      vecs[i].addr, vecs[i].data);
        end

        // Reset during a pending write drops the request without waiting for a clock
        hit_i     = 1'b1;
        m_ready_i = 1'b0;
        instr_i   = mk(9'h10A, 0, 0, 0, 3'd4, 1, 0, 0, 0, 0);
        @(posedge clock_i);
        #1;
        check_all(100, 16'd20, 0, 0, 0, 1, 4'd10, 16'd19);
        instr_i  = NOP;
        #1;
        reset_ni = 1'b0;
        #1;
        check_all(101, 16'd1, 0, 0, 0, 0, 4'd0, 16'h0000);
        @(negedge clock_i);
        reset_ni = 1'b1;
        @(posedge clock_i);
        #1;
        check_all(102, 16'd2, 0, 0, 0, 0, 4'd0, 16'h0000);
        @(posedge clock_i);
        #1;
        check_all(103, 16'd3, 0, 0, 0, 0, 4'd0, 16'h0000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/vga_tta_core.md
VGA_TTA_CORE -- requirements
Module: vga_tta

Interface
REQ-001 Parameters: none; all widths fixed.
REQ-002 clock_i  input  1  sole clock; all state updates on rising edge.
REQ-003 reset_ni  input  1  asynchronous, active-low reset.
REQ-004 pc_o  output  16  instruction fetch address, registered.
REQ-005 hit_i  input  1  instr_i valid for current pc_o; low = fetch miss.
REQ-006 instr_i  input  32  instruction word for pc_o, combinational from instruction memory.
REQ-007 newline_o  output  1  one-cycle registered pulse, start of display line.
REQ-008 newpage_o  output  1  one-cycle registered pulse, start of frame.
REQ-009 m_read_o  output  1  memory read request, held until m_ready_i.
REQ-010 m_write_o  output  1  memory write request, held until m_ready_i.
REQ-011 m_ready_i  input  1  memory completes current request this cycle.
REQ-012 m_addr_o  output  4  memory/port address.
REQ-013 m_data_i  input  16  read data, valid when m_ready_i high.
REQ-014 m_data_o  output  16  write data, held with m_write_o.

Function
REQ-015 Instruction fields: imm[31:23], rs[22:19], rd[18:15], wsrc[14:13], com[12:10], mem[9], ctl[8:7], bsel[6:5], aop[4:2], asel[1:0].
REQ-016 IMM = imm zero-extended to 16 bits; RF = 16 x 16-bit register file, combinational read port r[rs].
REQ-017 COM bus (combinational) per com: 000 r[rs], 001 IMM, 010 ALU result reg, 011 MDR (last read data), 100 pc_o, 101-111 zero.
REQ-018 ALU operand A per asel: 00 no trigger (ALU result reg holds), 01 r[rs], 10 COM, 11 IMM.
REQ-019 ALU operand B per bsel: 00 COM, 01 IMM, 10 r[rs], 11 constant 1.
REQ-020 aop: 000 A&B, 001 A|B, 010 A^B, 011 A+B, 100 A-B, 101 A>>1, 110 A+1, 111 A; 16-bit wrap, no flags.
REQ-021 When asel!=00, ALU result reg loads aop result at end of executing cycle; readable by next instruction.
REQ-022 RF write per wsrc: 00 none, 01 ALU result reg (old value), 10 COM, 11 IMM; written to r[rd] at end of cycle.
REQ-023 ctl: 00 none, 01 pulse newline_o next cycle, 10 pulse newpage_o next cycle, 11 jump: pc <= IMM.
REQ-024 Execute condition: hit_i high and no memory access pending; else no state changes except memory handshake.
REQ-025 Executing cycle without jump: pc <= pc+1 (16-bit wrap).
REQ-026 hit_i low: pc_o holds, instruction discarded, no pulses.
REQ-027 mem=1: start access; imm[8]=1 write, else read; m_addr_o <= imm[3:0]; m_data_o <= COM; request asserted from next cycle.
REQ-028 Access pending: m_read_o/m_write_o, m_addr_o, m_data_o stable; pc_o holds; execution stalls.
REQ-029 m_ready_i high while pending: request deasserts next cycle; read latches m_data_i into MDR; execution resumes next cycle.
REQ-030 m_ready_i while no request: ignored.
REQ-031 Same-cycle RF write and read of same register: read returns old value.

Reset
REQ-032 reset_ni low: pc_o=16'h0001; newline_o, newpage_o, m_read_o, m_write_o=0; m_addr_o=0; m_data_o=0; ALU result reg=0; MDR=0.
REQ-033 Reset mid-access abandons request immediately; RF contents not reset.
REQ-034 First fetch after reset release from address 1; address 0 never fetched unless jumped to.

Verification
REQ-035 Reset, hit_i=1, NOPs (all-zero except aop=111) -> pc_o 1,2,3,... one per clock; all outputs 0.
REQ-036 hit_i low 2 cycles mid-stream -> pc_o frozen; resumes +1 on hit_i high.
REQ-037 IMM=11, wsrc=11, rd=0; then rs=0, asel=01, bsel=11, aop=011; then wsrc=01, rd=1, com=000, rs=1 -> r1=12; COM shows 12 next.
REQ-038 ctl=11, IMM=1 at pc 9 -> pc_o=1 next cycle; ctl=01 -> newline_o high exactly one cycle.
REQ-039 mem=1, imm[8]=0, addr 5; m_ready_i after 3 cycles, m_data_i=16'hBEEF -> m_read_o high 3 cycles, m_addr_o=5, pc_o stalled; com=011 yields 16'hBEEF.
REQ-040 reset_ni low during pending write -> m_write_o=0 immediately; pc_o=1.
